// File: rtl/diff_stim_sequencer.sv
// Run controller for differential fuzzing: drives one LFSR stimulus into two DUT copies,
// folds both outputs into CRC-style signatures and latches the first disagreeing vector.
module diff_stim_sequencer #(
  parameter int STIM_W           = 52,
  parameter int Y_W              = 924,
  parameter bit STOP_ON_MISMATCH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       seed,
  input  logic [15:0]       num_vec,
  input  logic [3:0]        settle,
  output logic [STIM_W-1:0] stim_out,
  input  logic [Y_W-1:0]    y_a,
  input  logic [Y_W-1:0]    y_b,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [15:0]       mismatch_idx,
  output logic [31:0]       sig_a,
  output logic [31:0]       sig_b
);

  localparam int          NCH       = (Y_W + 31) / 32;
  localparam logic [63:0] LFSR_MASK = 64'hB000000000000001;
  localparam logic [31:0] SIG_POLY  = 32'h04C11DB7;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  function automatic logic [31:0] fold_chunks(input logic [Y_W-1:0] y);
    logic [NCH*32-1:0] padded;
    logic [31:0]       f;
    padded          = '0;
    padded[Y_W-1:0] = y;
    f               = '0;
    for (int i = 0; i < NCH; i++) f = f ^ padded[i*32 +: 32];
    return f;
  endfunction

  function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [31:0] f);
    return {sig[30:0], 1'b0} ^ (sig[31] ? SIG_POLY : 32'h0) ^ f;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return {l[62:0], 1'b0} ^ (l[63] ? LFSR_MASK : 64'h0);
  endfunction

  state_t              state_q;
  logic [63:0]         lfsr_q;
  logic [15:0]         vec_cnt_q, num_vec_q;
  logic [3:0]          settle_q, wait_q;
  logic [STIM_W-1:0]   stim_q;
  logic                busy_q, done_q, mm_q;
  logic [15:0]         mm_idx_q;
  logic [31:0]         sig_a_q, sig_b_q;

  logic [31:0]         sig_a_d, sig_b_d;
  logic [63:0]         lfsr_d;
  logic                mm_hit, last_vec;

  always_comb begin
    sig_a_d  = sig_step(sig_a_q, fold_chunks(y_a));
    sig_b_d  = sig_step(sig_b_q, fold_chunks(y_b));
    lfsr_d   = lfsr_step(lfsr_q);
    mm_hit   = (y_a != y_b) && !mm_q;
    // 17-bit compare so num_vec = 65535 terminates without counter wrap
    last_vec = (({1'b0, vec_cnt_q} + 17'd1) == {1'b0, num_vec_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= 64'h1;
      vec_cnt_q <= '0;
      num_vec_q <= '0;
      settle_q  <= '0;
      wait_q    <= '0;
      stim_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mm_q      <= 1'b0;
      mm_idx_q  <= '0;
      sig_a_q   <= '0;
      sig_b_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          stim_q <= '0;
          if (start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          settle_q  <= settle;
          num_vec_q <= num_vec;
          lfsr_q    <= (seed == 64'h0) ? 64'h1 : seed;
          vec_cnt_q <= '0;
          sig_a_q   <= 32'hFFFFFFFF;
          sig_b_q   <= 32'hFFFFFFFF;
          mm_q      <= 1'b0;
          mm_idx_q  <= '0;
          if (num_vec == 16'd0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_APPLY;
          end
        end
        S_APPLY: begin
          stim_q  <= (vec_cnt_q == 16'd0) ? '0 : lfsr_q[STIM_W-1:0];
          wait_q  <= settle_q - 4'd1;
          state_q <= (settle_q != 4'd0) ? S_SETTLE : S_SAMPLE;
        end
        S_SETTLE: begin
          if (wait_q == 4'd0) state_q <= S_SAMPLE;
          else                wait_q  <= wait_q - 4'd1;
        end
        S_SAMPLE: begin
          sig_a_q <= sig_a_d;
          sig_b_q <= sig_b_d;
          if (mm_hit) begin
            mm_q     <= 1'b1;
            mm_idx_q <= vec_cnt_q;
          end
          // vector 1 uses the seed itself, so the LFSR only advances from vector 1 on
          if (vec_cnt_q != 16'd0) lfsr_q <= lfsr_d;
          vec_cnt_q <= vec_cnt_q + 16'd1;
          if (last_vec || (mm_hit && STOP_ON_MISMATCH)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_APPLY;
          end
        end
        S_DONE: begin
          if (start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stim_out     = stim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mismatch     = mm_q;
  assign mismatch_idx = mm_idx_q;
  assign sig_a        = sig_a_q;
  assign sig_b        = sig_b_q;

endmodule

// File: tb/tb_diff_stim_sequencer.sv
// Directed bench for diff_stim_sequencer: two instances (free-running and stop-on-mismatch)
// fed by a combinational stand-in DUT, checked against a behavioural run model.
module tb_diff_stim_sequencer;
  localparam int          STIM_W = 52;
  localparam int          Y_W    = 924;
  localparam logic [63:0] SEED_A = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, fault;
  logic [63:0]       seed;
  logic [15:0]       num_vec;
  logic [3:0]        settle;
  logic [STIM_W-1:0] stim0, stim1;
  logic [Y_W-1:0]    ya0, yb0, ya1, yb1;
  logic              busy0, done0, mm0, busy1, done1, mm1;
  logic [15:0]       idx0, idx1;
  logic [31:0]       sa0, sb0, sa1, sb1;

  int checks   = 0;
  int failures = 0;
  logic [STIM_W-1:0] rec   [0:63];
  logic [STIM_W-1:0] rec_z [0:63];

  function automatic logic [Y_W-1:0] ymodel(input logic [STIM_W-1:0] s);
    logic [Y_W-1:0] y;
    for (int i = 0; i < Y_W; i++) y[i] = s[i % STIM_W] ^ s[(i / STIM_W) % STIM_W];
    return y;
  endfunction

  function automatic logic [31:0] xfold(input logic [Y_W-1:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < Y_W; i++) f[i % 32] = f[i % 32] ^ y[i];
    return f;
  endfunction

  function automatic logic [31:0] crc(input logic [31:0] s, input logic [31:0] f);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  always_comb begin
    ya0 = ymodel(stim0);
    yb0 = ya0;
    yb0[0] = ya0[0] ^ fault;
    ya1 = ymodel(stim1);
    yb1 = ya1;
    yb1[0] = ya1[0] ^ fault;
  end

  diff_stim_sequencer #(.STIM_W(STIM_W), .Y_W(Y_W), .STOP_ON_MISMATCH(1'b0)) u_free (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .num_vec(num_vec), .settle(settle),
    .stim_out(stim0), .y_a(ya0), .y_b(yb0), .busy(busy0), .done(done0), .mismatch(mm0),
    .mismatch_idx(idx0), .sig_a(sa0), .sig_b(sb0));

  diff_stim_sequencer #(.STIM_W(STIM_W), .Y_W(Y_W), .STOP_ON_MISMATCH(1'b1)) u_stop (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .num_vec(num_vec), .settle(settle),
    .stim_out(stim1), .y_a(ya1), .y_b(yb1), .busy(busy1), .done(done1), .mismatch(mm1),
    .mismatch_idx(idx1), .sig_a(sa1), .sig_b(sb1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [63:0] sd, input int n, input int fidx, input bit stop,
                       output logic [31:0] ea, output logic [31:0] eb, output bit emm,
                       output logic [15:0] eidx, output int nrun);
    logic [63:0]       l;
    logic [STIM_W-1:0] st;
    logic [Y_W-1:0]    y1, y2;
    l = (sd == 64'h0) ? 64'h1 : sd;
    ea = 32'hFFFFFFFF; eb = 32'hFFFFFFFF; emm = 1'b0; eidx = '0; nrun = n;
    for (int k = 0; k < n; k++) begin
      st = (k == 0) ? '0 : l[STIM_W-1:0];
      y1 = ymodel(st);
      y2 = y1;
      if (k == fidx) y2[0] = ~y2[0];
      ea = crc(ea, xfold(y1));
      eb = crc(eb, xfold(y2));
      if ((y1 != y2) && !emm) begin
        emm = 1'b1;
        eidx = k[15:0];
        if (stop) begin
          nrun = k + 1;
          break;
        end
      end
      if (k >= 1) l = (l << 1) ^ (l[63] ? 64'hB000000000000001 : 64'h0);
    end
  endtask

  // Cycle j counts from the LOAD cycle (j=1); returns the cycle in which done is seen.
  task automatic run(input logic [63:0] sd, input int n, input int s, input int fidx,
                     input bit sel, input int dbl_at, input int rst_at, output int cyc);
    int j, t, k, ph;
    seed = sd; num_vec = n[15:0]; settle = s[3:0]; fault = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    j = 1;
    while (j < 3000) begin
      if (sel ? done1 : done0) break;
      if (j == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        break;
      end
      fault = 1'b0;
      if (j >= 2) begin
        t = j - 2; k = t / (s + 2); ph = t % (s + 2);
        fault = (k == fidx) && (ph >= 1);
        if (ph == s + 1 && k < 64) rec[k] = stim0;
      end
      if (j == dbl_at) begin
        start = 1'b1; seed = ~sd; num_vec = 16'd3; settle = 4'd0;
      end else if (j == dbl_at + 1) begin
        start = 1'b0; seed = sd; num_vec = n[15:0]; settle = s[3:0];
      end
      @(negedge clk);
      j++;
    end
    fault = 1'b0;
    cyc = j;
  endtask

  initial begin
    logic [31:0] ga, gb, gold_a, za, zb;
    logic [15:0] gidx;
    bit          gmm;
    int          nrun, cyc;

    rst = 1'b1; start = 1'b0; fault = 1'b0; seed = '0; num_vec = '0; settle = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_stim", stim0, 0);
    check("rst_sig_a", sa0, 0);
    check("rst_mm", mm0, 0);
    rst = 1'b0;

    // empty run
    run(SEED_A, 0, 1, -1, 0, -1, -1, cyc);
    check("nv0_cycles", cyc, 2);
    check("nv0_sig_a", sa0, 32'hFFFFFFFF);
    check("nv0_sig_b", sb0, 32'hFFFFFFFF);
    check("nv0_mm", mm0, 0);
    check("nv0_stim", stim0, 0);
    check("nv0_busy", busy0, 0);

    // clean 21-vector run, restarted from DONE
    model(SEED_A, 21, -1, 0, ga, gb, gmm, gidx, nrun);
    gold_a = ga;
    run(SEED_A, 21, 1, -1, 0, -1, -1, cyc);
    check("clean_cycles", cyc, 65);
    check("clean_mm", mm0, 0);
    check("clean_sig_a", sa0, ga);
    check("clean_sig_b", sb0, gb);
    check("clean_a_eq_b", sa0, sb0);

    // single-bit fault on vector 5, run continues
    model(SEED_A, 21, 5, 0, ga, gb, gmm, gidx, nrun);
    run(SEED_A, 21, 1, 5, 0, -1, -1, cyc);
    check("fault_cycles", cyc, 65);
    check("fault_mm", mm0, 1);
    check("fault_idx", idx0, 5);
    check("fault_sig_a", sa0, ga);
    check("fault_sig_b", sb0, gb);
    check("fault_a_ne_b", (sa0 != sb0), 1);

    // same fault, stop-on-mismatch instance
    model(SEED_A, 21, 5, 1, ga, gb, gmm, gidx, nrun);
    run(SEED_A, 21, 1, 5, 1, -1, -1, cyc);
    check("stop_cycles", cyc, 20);
    check("stop_model_len", cyc, 2 + nrun * 3);
    check("stop_mm", mm1, 1);
    check("stop_idx", idx1, 5);
    check("stop_sig_a", sa1, ga);
    check("stop_sig_b", sb1, gb);
    check("stop_busy_done", {busy1, done1}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // longer settle
    model(SEED_A, 4, -1, 0, ga, gb, gmm, gidx, nrun);
    run(SEED_A, 4, 3, -1, 0, -1, -1, cyc);
    check("settle3_cycles", cyc, 22);
    check("settle3_sig_a", sa0, ga);

    // seed 0 and seed 1 produce the same run
    run(64'h0, 21, 0, -1, 0, -1, -1, cyc);
    check("seed0_cycles", cyc, 44);
    za = sa0; zb = sb0;
    for (int i = 0; i < 21; i++) rec_z[i] = rec[i];
    run(64'h1, 21, 0, -1, 0, -1, -1, cyc);
    check("seed1_sig_a", sa0, za);
    check("seed1_sig_b", sb0, zb);
    for (int i = 0; i < 21; i++) check($sformatf("seed_vec%0d", i), rec[i], rec_z[i]);
    check("seed_vec0_zero", rec_z[0], 0);
    check("seed_vec1", rec_z[1], 1);
    check("seed_vec2", rec_z[2], 2);
    model(64'h1, 21, -1, 0, ga, gb, gmm, gidx, nrun);
    check("seed1_sig_gold", sa0, ga);

    // abort at cycle 30, then a fresh run with an ignored mid-run start and input changes
    run(SEED_A, 21, 1, -1, 0, -1, 30, cyc);
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_sig_a", sa0, 0);
    check("abort_sig_b", sb0, 0);
    check("abort_stim", stim0, 0);
    check("abort_idx", idx0, 0);
    rst = 1'b0;
    run(SEED_A, 21, 1, -1, 0, 10, -1, cyc);
    check("rerun_cycles", cyc, 65);
    check("rerun_sig_a", sa0, gold_a);
    check("rerun_a_eq_b", sb0, gold_a);
    check("rerun_mm", mm0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
